// File: rtl/button_event_arbiter.sv
// button_event_arbiter: shared-tick debouncer for N buttons feeding a round-robin press/release event slot.
// Define BTN_AUTOREPEAT_EN to add auto-repeat events (and the evt_repeat port) for held buttons.
module button_event_arbiter #(
    parameter int N              = 4,
    parameter int TICK_DIV       = 270000,
    parameter int STABLE_SAMPLES = 3,
    parameter int HOLD_TICKS     = 50,
    parameter int REPEAT_TICKS   = 10,
    localparam int IW            = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  noisy,
    output logic [N-1:0]  clean,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [IW-1:0] evt_id,
    output logic          evt_press,
`ifdef BTN_AUTOREPEAT_EN
    output logic          evt_repeat,
`endif
    output logic [N-1:0]  overrun,
    input  logic          clear_overrun
);
    localparam int CW = $clog2(TICK_DIV);

    if (N < 1 || N > 16 || TICK_DIV < 2 || STABLE_SAMPLES < 1 || STABLE_SAMPLES > 7
        || REPEAT_TICKS < 1 || REPEAT_TICKS > HOLD_TICKS) begin : g_bad_cfg
        $error("button_event_arbiter: illegal parameter set");
    end

    logic [N-1:0]  s_meta, s, flip, set, set_kind, clr, pend, kind;
    logic [2:0]    stab [N];
    logic [CW-1:0] cnt;
    logic [IW-1:0] ptr, sel;
    logic          tick, found, load;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s_meta <= '0;
            s      <= '0;
        end else begin
            s_meta <= noisy;
            s      <= s_meta;
        end
    end

    assign tick = cnt == CW'(TICK_DIV - 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt <= '0;
        else        cnt <= tick ? '0 : cnt + CW'(1);
    end

    // flip marks the tick on which the stability count completes
    always_comb begin
        for (int i = 0; i < N; i++)
            flip[i] = tick && s[i] != clean[i] && stab[i] == 3'(STABLE_SAMPLES - 1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clean <= '0;
            for (int i = 0; i < N; i++) stab[i] <= '0;
        end else begin
            clean <= clean ^ flip;
            if (tick)
                for (int i = 0; i < N; i++)
                    stab[i] <= (s[i] == clean[i] || flip[i]) ? 3'd0 : stab[i] + 3'd1;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int HW = $clog2(HOLD_TICKS + 1);
    logic [HW-1:0] hold [N];
    logic [N-1:0]  fire, rep;

    always_comb begin
        for (int i = 0; i < N; i++)
            fire[i] = tick && clean[i] && !flip[i] && hold[i] == HW'(HOLD_TICKS - 1);
    end

    assign set      = flip | fire;
    assign set_kind = ~clean | fire;

    // after each repeat the counter is rewound so the next one lands REPEAT_TICKS later
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rep <= '0;
            for (int i = 0; i < N; i++) hold[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (set[i]) rep[i] <= fire[i];
                if (!clean[i] || flip[i]) hold[i] <= '0;
                else if (tick)            hold[i] <= fire[i] ? HW'(HOLD_TICKS - REPEAT_TICKS) : hold[i] + HW'(1);
            end
        end
    end
`else
    assign set      = flip;
    assign set_kind = ~clean;
`endif

    // descending scan so the candidate closest to ptr is the last one written
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (pend[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                sel   = IW'((int'(ptr) + k) % N);
            end
        end
        load = !evt_valid || evt_ready;
        clr  = '0;
        if (load && found) clr[sel] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend      <= '0;
            kind      <= '0;
            overrun   <= '0;
            ptr       <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_press <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            evt_repeat <= 1'b0;
`endif
        end else begin
            pend    <= (pend & ~clr) | set;
            kind    <= (kind & ~set) | (set_kind & set);
            overrun <= clear_overrun ? '0 : overrun | (set & pend & ~clr);
            if (load) begin
                evt_valid <= found;
                if (found) begin
                    evt_id    <= sel;
                    evt_press <= kind[sel];
                    ptr       <= (sel == IW'(N - 1)) ? '0 : sel + IW'(1);
`ifdef BTN_AUTOREPEAT_EN
                    evt_repeat <= rep[sel];
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: directed scenarios for button_event_arbiter with N=4, TICK_DIV=4, STABLE_SAMPLES=3.
// Define BTN_AUTOREPEAT_EN for both files to include the auto-repeat scenario.
module tb_button_event_arbiter;
    logic       clock = 1'b0, reset = 1'b0, evt_ready = 1'b0, clear_overrun = 1'b0;
    logic [3:0] noisy = '0, clean, overrun;
    logic       evt_valid, evt_press;
    logic [1:0] evt_id;
`ifdef BTN_AUTOREPEAT_EN
    logic       evt_repeat;
`endif
    int tests = 0, fails = 0;

    button_event_arbiter #(
        .N(4), .TICK_DIV(4), .STABLE_SAMPLES(3), .HOLD_TICKS(2), .REPEAT_TICKS(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .noisy(noisy),
        .clean(clean),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_id(evt_id),
        .evt_press(evt_press),
`ifdef BTN_AUTOREPEAT_EN
        .evt_repeat(evt_repeat),
`endif
        .overrun(overrun),
        .clear_overrun(clear_overrun)
    );

    always #5 clock = ~clock;

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        noisy = '0;
        evt_ready = 1'b0;
        clear_overrun = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(1);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            if (evt_valid) ok = 1'b1;
            else @(negedge clock);
        end
    endtask

    task automatic wait_clean(input int i, input logic v, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            if (clean[i] === v) ok = 1'b1;
            else @(negedge clock);
        end
    endtask

    task automatic test_reset();
        do_reset();
        evt_ready = 1'b1;
        cyc(3);
        tests++; if (clean !== 4'b0000) begin fails++; $display("FAIL reset_clean: got %b want 0000", clean); end
        tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        tests++; if (evt_id !== 2'd0) begin fails++; $display("FAIL reset_id: got %0d want 0", evt_id); end
        tests++; if (evt_press !== 1'b0) begin fails++; $display("FAIL reset_press: got %b want 0", evt_press); end
        tests++; if (overrun !== 4'b0000) begin fails++; $display("FAIL reset_overrun: got %b want 0000", overrun); end
    endtask

    task automatic test_bounce();
        int nev = 0, rises = 0;
        logic prev = 1'b0, pr = 1'b0;
        logic [1:0] id = '0;
        do_reset();
        evt_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (c < 40 && c % 3 == 0) noisy[1] = ~noisy[1];
            if (c == 40) noisy[1] = 1'b1;
            @(negedge clock);
            if (evt_valid) begin nev++; id = evt_id; pr = evt_press; end
            if (clean[1] && !prev) rises++;
            prev = clean[1];
        end
        tests++; if (rises != 1) begin fails++; $display("FAIL bounce_rises: got %0d want 1", rises); end
        tests++; if (clean !== 4'b0010) begin fails++; $display("FAIL bounce_clean: got %b want 0010", clean); end
        tests++; if (nev != 1) begin fails++; $display("FAIL bounce_events: got %0d want 1", nev); end
        tests++; if (id !== 2'd1 || pr !== 1'b1) begin fails++; $display("FAIL bounce_event: got id=%0d press=%b want id=1 press=1", id, pr); end
        tests++; if (overrun !== 4'b0000) begin fails++; $display("FAIL bounce_overrun: got %b want 0000", overrun); end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        evt_ready = 1'b1;
        noisy = 4'hF;
        wait_valid(ok);
        tests++; if (!ok) begin fails++; $display("FAIL rr_timeout: got no event want event"); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (evt_valid !== 1'b1 || evt_id !== 2'(i) || evt_press !== 1'b1) begin
                fails++; $display("FAIL rr_event%0d: got v=%b id=%0d p=%b want v=1 id=%0d p=1", i, evt_valid, evt_id, evt_press, i);
            end
            @(negedge clock);
        end
        tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL rr_drained: got valid=%b want 0", evt_valid); end
    endtask

    task automatic test_overrun();
        bit ok, ok1, ok2;
        do_reset();
        noisy[0] = 1'b1;
        wait_valid(ok);
        noisy[2] = 1'b1;
        wait_clean(2, 1'b1, ok1);
        noisy[2] = 1'b0;
        wait_clean(2, 1'b0, ok2);
        cyc(1);
        tests++; if (!(ok && ok1 && ok2)) begin fails++; $display("FAIL ovr_timeout: got %b%b%b want 111", ok, ok1, ok2); end
        tests++; if (overrun !== 4'b0100) begin fails++; $display("FAIL ovr_set: got %b want 0100", overrun); end
        tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_press !== 1'b1) begin
            fails++; $display("FAIL ovr_hold: got v=%b id=%0d p=%b want v=1 id=0 p=1", evt_valid, evt_id, evt_press);
        end
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_press !== 1'b0) begin
            fails++; $display("FAIL ovr_next: got v=%b id=%0d p=%b want v=1 id=2 p=0", evt_valid, evt_id, evt_press);
        end
        tests++; if (overrun !== 4'b0100) begin fails++; $display("FAIL ovr_sticky: got %b want 0100", overrun); end
        clear_overrun = 1'b1;
        cyc(1);
        clear_overrun = 1'b0;
        tests++; if (overrun !== 4'b0000) begin fails++; $display("FAIL ovr_clear: got %b want 0000", overrun); end
    endtask

    task automatic test_own_slot();
        bit ok, ok1;
        do_reset();
        noisy[3] = 1'b1;
        wait_valid(ok);
        tests++; if (!ok || evt_id !== 2'd3 || evt_press !== 1'b1) begin
            fails++; $display("FAIL own_press: got ok=%b id=%0d p=%b want ok=1 id=3 p=1", ok, evt_id, evt_press);
        end
        noisy[3] = 1'b0;
        wait_clean(3, 1'b0, ok1);
        cyc(1);
        tests++; if (!ok1 || overrun !== 4'b0000) begin fails++; $display("FAIL own_overrun: got ok=%b ovr=%b want ok=1 ovr=0000", ok1, overrun); end
        tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd3 || evt_press !== 1'b1) begin
            fails++; $display("FAIL own_stable: got v=%b id=%0d p=%b want v=1 id=3 p=1", evt_valid, evt_id, evt_press);
        end
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd3 || evt_press !== 1'b0) begin
            fails++; $display("FAIL own_release: got v=%b id=%0d p=%b want v=1 id=3 p=0", evt_valid, evt_id, evt_press);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int n;
        do_reset();
        noisy[0] = 1'b1;
        wait_valid(ok);
        tests++; if (!ok || clean !== 4'b0001) begin fails++; $display("FAIL ar_pre: got ok=%b clean=%b want ok=1 clean=0001", ok, clean); end
        noisy[1] = 1'b1;
        cyc(8);
        #2 reset = 1'b0;
        #1;
        tests++; if (clean !== 4'b0000 || evt_valid !== 1'b0 || evt_press !== 1'b0 || overrun !== 4'b0000) begin
            fails++; $display("FAIL ar_zero: got clean=%b v=%b p=%b ovr=%b want all 0", clean, evt_valid, evt_press, overrun);
        end
        noisy[1] = 1'b0;
        cyc(2);
        reset = 1'b1;
        for (n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (evt_valid) break;
        end
        tests++; if (n != 13) begin fails++; $display("FAIL ar_latency: got %0d cycles want 13", n); end
        tests++; if (evt_id !== 2'd0 || evt_press !== 1'b1 || clean !== 4'b0001) begin
            fails++; $display("FAIL ar_event: got id=%0d p=%b clean=%b want id=0 p=1 clean=0001", evt_id, evt_press, clean);
        end
    endtask

`ifdef BTN_AUTOREPEAT_EN
    task automatic test_autorepeat();
        bit ok, got;
        int n;
        logic rv;
        do_reset();
        evt_ready = 1'b1;
        noisy[0] = 1'b1;
        wait_valid(ok);
        tests++; if (!ok || evt_press !== 1'b1 || evt_repeat !== 1'b0) begin
            fails++; $display("FAIL rep_press: got ok=%b p=%b r=%b want ok=1 p=1 r=0", ok, evt_press, evt_repeat);
        end
        for (int k = 0; k < 2; k++) begin
            for (n = 1; n <= 20; n++) begin
                @(negedge clock);
                if (evt_valid) break;
            end
            tests++; if (n != (k == 0 ? 8 : 4) || evt_press !== 1'b1 || evt_repeat !== 1'b1 || evt_id !== 2'd0) begin
                fails++; $display("FAIL rep_%0d: got gap=%0d p=%b r=%b id=%0d want gap=%0d p=1 r=1 id=0", k, n, evt_press, evt_repeat, evt_id, k == 0 ? 8 : 4);
            end
        end
        noisy[0] = 1'b0;
        got = 1'b0;
        rv = 1'bx;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clock);
            if (evt_valid && !evt_press) begin got = 1'b1; rv = evt_repeat; end
        end
        tests++; if (!got || rv !== 1'b0) begin fails++; $display("FAIL rep_release: got seen=%b r=%b want seen=1 r=0", got, rv); end
    endtask
`endif

    initial begin
        test_reset();
        test_bounce();
        test_round_robin();
        test_overrun();
        test_own_slot();
        test_async_reset();
`ifdef BTN_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
